// File: rtl/stream_capture_checker.sv
// stream_capture_checker: receive-side sink for the EzLogic byte stream.
// Packs N bytes in arrival order into data_all (byte 0 in the MSBs), then
// compares the full vector against EXPECTED and reports done/success.
// Flags an idle timeout while waiting for bytes and overflow bytes after done.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          single-cycle arm pulse; full clear, begins capture
//   data_in        stream byte
//   valid_in       byte qualifier
//   data_all       captured bytes, byte i at [8*N-1-8*i -: 8]
//   byte_count     bytes accepted since the last start (saturates at N)
//   done           capture finished (completed or timed out), held until start
//   success        valid with done: all N bytes received and data_all==EXPECTED
//   err_timeout    sticky, capture aborted by idle timeout
//   err_overflow   sticky, valid_in seen after done
module stream_capture_checker #(
  parameter int unsigned       N        = 42,
  parameter logic [8*N-1:0]    EXPECTED = 336'h30789d5692f2fe23bb2c5d9e16406653b6cb217c952998ce17b7143788d949952680b4bce4c30a96c753,
  parameter int unsigned       TIMEOUT  = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       data_in,
  input  logic             valid_in,
  output logic [8*N-1:0]   data_all,
  output logic [6:0]       byte_count,
  output logic             done,
  output logic             success,
  output logic             err_timeout,
  output logic             err_overflow
);

  localparam int unsigned W      = 8 * N;
  localparam int unsigned CNT_W  = 7;
  localparam int unsigned IDLE_W = 8;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(N);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic [W-1:0]       data_d;
  logic [CNT_W-1:0]   cnt_d;
  logic               done_d, success_d, tmo_d, ovf_d;

  // Next-state and next-output logic; all outputs are registered below.
  always_comb begin
    state_d   = state_q;
    idle_d    = idle_q;
    data_d    = data_all;
    cnt_d     = byte_count;
    done_d    = done;
    success_d = success;
    tmo_d     = err_timeout;
    ovf_d     = err_overflow;

    if (start) begin
      // start outranks everything, including a byte arriving this cycle
      state_d   = S_CAPTURE;
      idle_d    = '0;
      data_d    = '0;
      cnt_d     = '0;
      done_d    = 1'b0;
      success_d = 1'b0;
      tmo_d     = 1'b0;
      ovf_d     = 1'b0;
    end else begin
      case (state_q)
        S_CAPTURE: begin
          if (valid_in) begin
            for (int unsigned i = 0; i < N; i++) begin
              if (byte_count == CNT_W'(i)) begin
                data_d[W-1-8*i -: 8] = data_in;
              end
            end
            if (byte_count != CNT_MAX) begin
              cnt_d = byte_count + CNT_W'(1);
            end
            idle_d = '0;
            if (byte_count == CNT_LAST) begin
              state_d = S_CHECK;
            end
          end else begin
            if (idle_q < IDLE_MAX) begin
              idle_d = idle_q + IDLE_W'(1);
            end
            // idle count runs from arming, so a silent stream also times out
            if (idle_d >= IDLE_MAX) begin
              state_d   = S_DONE;
              done_d    = 1'b1;
              success_d = 1'b0;
              tmo_d     = 1'b1;
            end
          end
        end
        S_CHECK: begin
          success_d = (data_all == EXPECTED);
          done_d    = 1'b1;
          state_d   = S_DONE;
        end
        S_DONE: begin
          // late bytes are discarded but remembered
          if (valid_in) begin
            ovf_d = 1'b1;
          end
        end
        default: begin
          // idle: stream is ignored until armed
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idle_q       <= '0;
      data_all     <= '0;
      byte_count   <= '0;
      done         <= 1'b0;
      success      <= 1'b0;
      err_timeout  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      state_q      <= state_d;
      idle_q       <= idle_d;
      data_all     <= data_d;
      byte_count   <= cnt_d;
      done         <= done_d;
      success      <= success_d;
      err_timeout  <= tmo_d;
      err_overflow <= ovf_d;
    end
  end

endmodule

// File: tb/tb_stream_capture_checker.sv
// Testbench for stream_capture_checker: a small (N=4) and a full-size (N=42)
// instance share the byte stream; each has its own start. Expected results are
// computed from the message (bytes + idle gaps) and queued; per-instance
// monitors pop and compare whenever done rises.
module tb_stream_capture_checker;

  localparam int unsigned NA   = 4;
  localparam logic [31:0] EXPA = 32'h30789d56;
  localparam int unsigned TOA  = 8;
  localparam int unsigned NB   = 42;
  localparam logic [335:0] EXPB = 336'h30789d5692f2fe23bb2c5d9e16406653b6cb217c952998ce17b7143788d949952680b4bce4c30a96c753;
  localparam int unsigned TOB  = 64;

  logic         clk;
  logic         rst_n;
  logic         start_a, start_b;
  logic [7:0]   data_in;
  logic         valid_in;
  logic [31:0]  data_a;
  logic [335:0] data_b;
  logic [6:0]   cnt_a, cnt_b;
  logic         done_a, succ_a, tmo_a, ovf_a;
  logic         done_b, succ_b, tmo_b, ovf_b;

  stream_capture_checker #(.N(NA), .EXPECTED(EXPA), .TIMEOUT(TOA)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .data_in(data_in), .valid_in(valid_in),
    .data_all(data_a), .byte_count(cnt_a), .done(done_a), .success(succ_a),
    .err_timeout(tmo_a), .err_overflow(ovf_a)
  );

  stream_capture_checker #(.N(NB), .EXPECTED(EXPB), .TIMEOUT(TOB)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .data_in(data_in), .valid_in(valid_in),
    .data_all(data_b), .byte_count(cnt_b), .done(done_b), .success(succ_b),
    .err_timeout(tmo_b), .err_overflow(ovf_b)
  );

  typedef struct {
    int           edge_n;
    logic         ok;
    logic         tmo;
    int           cnt;
    logic [335:0] data;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  exp_t ea, eb;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic done_a_q = 1'b0;
  logic done_b_q = 1'b0;

  logic [7:0] msg_b [64];
  int         msg_g [64];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [335:0] act, input logic [335:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the small instance.
  always @(negedge clk) begin
    if (done_a && !done_a_q) begin
      if (sb_a.size() == 0) begin
        chk("a_unexpected_done", 1, 0);
      end else begin
        ea = sb_a.pop_front();
        chk("a_done_edge", 336'(cyc), 336'(ea.edge_n));
        chk("a_success", 336'(succ_a), 336'(ea.ok));
        chk("a_err_timeout", 336'(tmo_a), 336'(ea.tmo));
        chk("a_err_overflow", 336'(ovf_a), 0);
        chk("a_byte_count", 336'(cnt_a), 336'(ea.cnt));
        chk("a_data_all", 336'(data_a), ea.data);
      end
    end
    done_a_q = done_a;
  end

  // Monitor for the full-size instance.
  always @(negedge clk) begin
    if (done_b && !done_b_q) begin
      if (sb_b.size() == 0) begin
        chk("b_unexpected_done", 1, 0);
      end else begin
        eb = sb_b.pop_front();
        chk("b_done_edge", 336'(cyc), 336'(eb.edge_n));
        chk("b_success", 336'(succ_b), 336'(eb.ok));
        chk("b_err_timeout", 336'(tmo_b), 336'(eb.tmo));
        chk("b_err_overflow", 336'(ovf_b), 0);
        chk("b_byte_count", 336'(cnt_b), 336'(eb.cnt));
        chk("b_data_all", data_b, eb.data);
      end
    end
    done_b_q = done_b;
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_byte(input logic [7:0] d);
    valid_in = 1'b1;
    data_in  = d;
    tick();
    valid_in = 1'b0;
  endtask

  // Arm one instance, predict the outcome of msg_b/msg_g, queue it, stream it.
  task automatic run_msg(input bit use_b, input int nb, input bit collide);
    int n, to, s, e, cnt, dn;
    bit timed;
    logic [335:0] ref_v, expv;
    exp_t r;
    n    = use_b ? NB : NA;
    to   = use_b ? TOB : TOA;
    expv = use_b ? EXPB : 336'(EXPA);

    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    if (collide) begin
      valid_in = 1'b1;
      data_in  = 8'hff;
    end else begin
      valid_in = 1'b0;
    end
    s = cyc + 1;

    // Reference: walk bytes and gaps; a gap of TIMEOUT idle edges aborts.
    e = s; cnt = 0; timed = 0;
    for (int i = 0; i < nb && cnt < n; i++) begin
      if (msg_g[i] >= to) begin
        timed = 1;
        break;
      end
      e = e + msg_g[i] + 1;
      cnt++;
    end
    if (cnt < n) timed = 1;
    dn = timed ? e + to : e + 1;
    ref_v = '0;
    for (int i = 0; i < cnt; i++) ref_v = (ref_v << 8) | 336'(msg_b[i]);
    ref_v = ref_v << (8 * (n - cnt));
    r.edge_n = dn;
    r.ok     = !timed && (ref_v == expv);
    r.tmo    = timed;
    r.cnt    = cnt;
    r.data   = ref_v;
    if (use_b) sb_b.push_back(r); else sb_a.push_back(r);

    tick();
    start_a  = 1'b0;
    start_b  = 1'b0;
    valid_in = 1'b0;
    if (collide) chk("collide_byte_count", 336'(use_b ? cnt_b : cnt_a), 0);

    for (int i = 0; i < cnt; i++) begin
      repeat (msg_g[i]) tick();
      drive_byte(msg_b[i]);
    end
    for (int k = 0; k < 400 && cyc <= dn; k++) tick();
  endtask

  task automatic load_a(input logic [31:0] v);
    for (int i = 0; i < 4; i++) begin
      msg_b[i] = v[31-8*i -: 8];
      msg_g[i] = 0;
    end
  endtask

  initial begin
    logic [31:0] va;
    logic [335:0] vb;
    int mode, j;

    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; valid_in = 1'b0; data_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_a", 336'(data_a), 0);
    chk("rst_cnt_a", 336'(cnt_a), 0);
    chk("rst_flags_a", 336'({done_a, succ_a, tmo_a, ovf_a}), 0);
    chk("rst_data_b", data_b, 0);
    chk("rst_flags_b", 336'({cnt_b, done_b, succ_b, tmo_b, ovf_b}), 0);
    rst_n = 1'b1;
    tick();

    // valid_in while idle is ignored
    drive_byte(8'h5a);
    chk("idle_ignores_valid", 336'({cnt_a, data_a}), 0);

    // happy path
    load_a(32'h30789d56);
    run_msg(0, 4, 0);

    // overflow in DONE: byte dropped, flag set, results held
    drive_byte(8'haa);
    chk("ovf_flag", 336'(ovf_a), 1);
    chk("ovf_data_held", 336'(data_a), 336'(32'h30789d56));
    chk("ovf_success_held", 336'({done_a, succ_a, cnt_a}), 336'({1'b1, 1'b1, 7'd4}));

    // mismatch in last byte (start also clears the overflow flag)
    load_a(32'h30789d57);
    run_msg(0, 4, 0);
    chk("mismatch_flags", 336'({tmo_a, ovf_a}), 0);

    // bubble of 3 idle cycles
    load_a(32'h30789d56);
    msg_g[1] = 3;
    run_msg(0, 4, 0);

    // timeout after two bytes
    run_msg(0, 2, 0);

    // stream that never starts
    run_msg(0, 0, 0);

    // restart with a colliding byte
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    drive_byte(8'h30);
    drive_byte(8'h78);
    load_a(32'h30789d56);
    run_msg(0, 4, 1);

    // randomized messages
    for (int t = 0; t < 24; t++) begin
      mode = $urandom_range(0, 3);
      va = (mode == 2) ? $urandom : EXPA;
      load_a(va);
      for (int i = 0; i < 4; i++) msg_g[i] = $urandom_range(0, 2);
      j = $urandom_range(0, 3);
      if (mode == 1) msg_b[j] = msg_b[j] ^ 8'($urandom_range(1, 255));
      if (mode == 3) msg_g[j] = $urandom_range(5, 10);
      run_msg(0, 4, 0);
    end
    load_a(32'h30789d56);
    run_msg(0, 4, 0);

    // asynchronous reset in the middle of a capture
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    drive_byte(8'h30);
    drive_byte(8'h78);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_data", 336'(data_a), 0);
    chk("async_rst_outs", 336'({cnt_a, done_a, succ_a, tmo_a, ovf_a}), 0);
    repeat (3) tick();
    chk("async_rst_no_done", 336'(done_a), 0);
    rst_n = 1'b1;
    tick();

    // full-size message back-to-back
    vb = EXPB;
    for (int i = 0; i < 42; i++) begin
      msg_b[i] = vb[335-8*i -: 8];
      msg_g[i] = 0;
    end
    run_msg(1, 42, 0);

    // full-size with random bubbles and an occasional corrupted byte
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 42; i++) begin
        msg_b[i] = vb[335-8*i -: 8];
        msg_g[i] = $urandom_range(0, 3);
      end
      if (t[0]) begin
        j = $urandom_range(0, 41);
        msg_b[j] = msg_b[j] ^ 8'h01;
      end
      run_msg(1, 42, 0);
    end

    repeat (4) tick();
    chk("sb_a_drained", 336'(sb_a.size()), 0);
    chk("sb_b_drained", 336'(sb_b.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/stream_capture_checker.md
Name: stream_capture_checker

Overview:
- Receive-side end of the EzLogic byte-stream interface: sinks the data_out/valid_out stream produced by EzLogic_top.
- Packs N bytes in arrival order into a wide register and compares it against a compile-time expected vector.
- Reports done/success, plus timeout and overflow errors.
- Synthesizable replacement for the bench-side capture logic, usable on FPGA with LEDs or a debug UART.

Parameters:
- N, 42, number of bytes per message (max 127).
- EXPECTED, 336'h30789d5692f2fe23bb2c5d9e16406653b6cb217c952998ce17b7143788d949952680b4bce4c30a96c753, reference vector of 8*N bits; byte 0 occupies the MSBs.
- TIMEOUT, 64, idle cycles tolerated while waiting for the next byte (max 255).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  single-cycle arm pulse; clears state and begins capture.
- data_in  in  8  stream byte, driven from EzLogic_top data_out.
- valid_in  in  1  byte qualifier, driven from EzLogic_top valid_out.
- data_all  out  8*N  captured bytes; byte i at bits [8*N-1-8*i -: 8].
- byte_count  out  7  bytes accepted since the last start.
- done  out  1  capture finished (completed or timed out); level, held until next start.
- success  out  1  valid only when done=1: 1 iff all N bytes were received and data_all==EXPECTED.
- err_timeout  out  1  sticky; capture aborted by idle timeout.
- err_overflow  out  1  sticky; valid_in seen while in DONE.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; data_all=0, byte_count=0, done=0, success=0, err_timeout=0, err_overflow=0, idle counter=0.
- States: IDLE, CAPTURE, CHECK, DONE.
- IDLE:
  - valid_in is ignored; nothing is recorded.
  - start=1 -> CAPTURE, clearing data_all, byte_count, idle counter, done, success and both error flags.
- CAPTURE:
  - Each edge with valid_in=1: data_in is written to the byte slot at byte_count, byte_count increments, idle counter clears.
  - When the accepted byte is byte N-1 -> CHECK.
  - Each edge with valid_in=0: idle counter increments.
  - Idle counter reaching TIMEOUT -> DONE with err_timeout=1 and success=0.
  - The timeout runs from the moment of arming, so a stream that never starts also times out.
- CHECK: exactly one cycle. Registers success=(data_all==EXPECTED) and done=1, then -> DONE.
- Latency: if the last byte is sampled at edge k, done and success are high after edge k+1.
- DONE:
  - Outputs hold their values.
  - valid_in=1 sets err_overflow=1; the byte is discarded and data_all/byte_count are unchanged.
  - start -> CAPTURE with a full clear.
- Start priority:
  - start in CAPTURE or CHECK restarts capture: partial data is discarded and a pending CHECK is abandoned.
  - start and valid_in high in the same cycle: start wins and the byte is dropped (byte_count=0 afterwards).
- Width rules:
  - Compare is a full 8*N-bit equality.
  - byte_count saturates at N and never wraps.
  - The idle counter is 8-bit and saturates at TIMEOUT.
- Reset asserted mid-capture returns to IDLE at once; a partial message never produces done.
- Bubbles on valid_in shorter than TIMEOUT cycles are legal; the packing order is unaffected.

Test Plan:
- Happy path: N=4, EXPECTED=32'h30789d56, TIMEOUT=8. Pulse start, then drive bytes 30,78,9d,56 on consecutive cycles -> done=1 exactly 1 cycle after the 56 edge; success=1; data_all=32'h30789d56; byte_count=4.
- Mismatch: same setup, drive 30,78,9d,57 -> done=1, success=0, data_all=32'h30789d57, no error flags set.
- Bubbles and timeout:
  - Drive 30, then 3 idle cycles, then 78,9d,56 -> success=1.
  - New start, drive 30,78, then 8 idle cycles -> done=1, err_timeout=1, success=0, byte_count=2.
- Overflow: after the happy path, drive valid_in=1 with data_in=aa -> err_overflow=1, data_all still 32'h30789d56, success stays 1. Next start clears err_overflow.
- Restart and collision:
  - Drive 30,78, then start with valid_in=1 and data_in=ff in the same cycle -> byte_count=0.
  - Then 30,78,9d,56 -> success=1.
- Async reset: assert rst_n=0 mid-edge after 2 bytes -> all outputs 0 immediately, no done.
- Full size: N=42 with the default EXPECTED streamed back-to-back -> success=1 at edge 43.
